e203_subsys_rst_seq: RTL

E203_SUBSYS_RST_SEQ -- requirements
Module: e203_subsys_rst_seq

---
 rtl/e203_subsys_rst_seq_if.sv | 30 +++
 rtl/e203_subsys_rst_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/e203_subsys_rst_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : e203_subsys_rst_seq_if
// Brief    : Request/drain/reset-output bundle of the subsystem reset sequencer.
// Revision : 1.0
// ============================================================================
interface e203_subsys_rst_seq_if;
    logic       sw_rst_req;
    logic       wdg_rst_req;
    logic       drain_ack;
    logic       drain_req;
    logic       bus_rst_n;
    logic       per_rst_n;
    logic       core_rst_n;
    logic [1:0] rst_cause;
    logic       seq_busy;

    // Requester / fabric side.
    modport master (
        output sw_rst_req, wdg_rst_req, drain_ack,
        input  drain_req, bus_rst_n, per_rst_n, core_rst_n, rst_cause, seq_busy
    );

    // Sequencer side.
    modport slave (
        input  sw_rst_req, wdg_rst_req, drain_ack,
        output drain_req, bus_rst_n, per_rst_n, core_rst_n, rst_cause, seq_busy
    );
endinterface
`default_nettype wire

// File: rtl/e203_subsys_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : e203_subsys_rst_seq
// Brief    : Staged bus/peripheral/core reset release with SW/WDG re-reset.
//            Optional bus drain before SW reset: E203_RST_SEQ_DRAIN_EN.
// Revision : 1.0
// ============================================================================
module e203_subsys_rst_seq #(
    parameter int unsigned HOLD_CYC  = 16,
    parameter int unsigned STAGE_GAP = 8,
    parameter int unsigned DRAIN_TO  = 255
) (
    input  logic                        clk,
    input  logic                        rst_a,
    e203_subsys_rst_seq_if.slave        rs
);

    localparam logic [7:0] C_HOLD_LAST  = 8'(HOLD_CYC - 1);
    localparam logic [7:0] C_GAP_LAST   = 8'(STAGE_GAP - 1);
    localparam logic [7:0] C_DRAIN_LAST = 8'(DRAIN_TO - 1);

    localparam logic [1:0] C_CAUSE_POR  = 2'b00;
    localparam logic [1:0] C_CAUSE_SW   = 2'b01;
    localparam logic [1:0] C_CAUSE_WDG  = 2'b10;
    localparam logic [1:0] C_CAUSE_TO   = 2'b11;

`ifdef E203_RST_SEQ_DRAIN_EN
    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        GAP1  = 3'd1,
        GAP2  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        GAP1  = 3'd1,
        GAP2  = 3'd2,
        RUN   = 3'd3
    } state_t;
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [1:0] r_rst_cause;
    logic [1:0] w_cause_nxt;
    logic       w_restart;
    logic       r_bus_rst_n;
    logic       r_per_rst_n;
    logic       r_core_rst_n;
    logic       r_seq_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_rst_cause;
        w_restart   = 1'b0;
        case (r_state)
            HOLD: if (r_cnt == C_HOLD_LAST) w_state_nxt = GAP1;
            GAP1: if (r_cnt == C_GAP_LAST)  w_state_nxt = GAP2;
            GAP2: if (r_cnt == C_GAP_LAST)  w_state_nxt = RUN;
            RUN: begin
                if (rs.sw_rst_req) begin
`ifdef E203_RST_SEQ_DRAIN_EN
                    w_state_nxt = DRAIN;
`else
                    w_state_nxt = HOLD;
`endif
                    w_cause_nxt = C_CAUSE_SW;
                end
            end
`ifdef E203_RST_SEQ_DRAIN_EN
            DRAIN: begin
                if (rs.drain_ack) begin
                    w_state_nxt = HOLD;
                end else if (r_cnt == C_DRAIN_LAST) begin
                    w_state_nxt = HOLD;
                    w_cause_nxt = C_CAUSE_TO;
                end
            end
`endif
            default: w_state_nxt = HOLD;
        endcase
        // Watchdog overrides everything, including a same-cycle SW request.
        if (rs.wdg_rst_req) begin
            w_state_nxt = HOLD;
            w_cause_nxt = C_CAUSE_WDG;
            w_restart   = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_restart || (w_state_nxt != r_state)) begin
            w_cnt_nxt = 8'd0;
        end else if (r_state != RUN) begin
            w_cnt_nxt = r_cnt + 8'd1;
        end
    end

    // Outputs are registered from the next-state decode so they track state flops.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_state      <= HOLD;
            r_cnt        <= 8'd0;
            r_rst_cause  <= C_CAUSE_POR;
            r_bus_rst_n  <= 1'b0;
            r_per_rst_n  <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_seq_busy   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rst_cause  <= w_cause_nxt;
            r_bus_rst_n  <= (w_state_nxt != HOLD);
            r_per_rst_n  <= (w_state_nxt != HOLD) && (w_state_nxt != GAP1);
            r_core_rst_n <= (w_state_nxt != HOLD) && (w_state_nxt != GAP1) &&
                            (w_state_nxt != GAP2);
            r_seq_busy   <= (w_state_nxt != RUN);
        end
    end

`ifdef E203_RST_SEQ_DRAIN_EN
    logic r_drain_req;

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_drain_req <= 1'b0;
        end else begin
            r_drain_req <= (w_state_nxt == DRAIN);
        end
    end

    assign rs.drain_req = r_drain_req;
`else
    logic w_unused_drain_ack;

    assign w_unused_drain_ack = rs.drain_ack;
    assign rs.drain_req       = 1'b0;
`endif

    assign rs.bus_rst_n  = r_bus_rst_n;
    assign rs.per_rst_n  = r_per_rst_n;
    assign rs.core_rst_n = r_core_rst_n;
    assign rs.rst_cause  = r_rst_cause;
    assign rs.seq_busy   = r_seq_busy;

endmodule
`default_nettype wire
